mac: RTL and testbench
======================

Name: mac

Overview:
- Unsigned multiply-accumulate unit.
- Each clock it multiplies operand x by weight w and adds the product into a running accumulator, which is presented on out.
- Serves as the basic compute element for dot-product / filter datapaths.
- Single clock domain; synchronous active-high reset clears the accumulator.

Parameters:
- N, 8, width in bits of each operand (x, w); accumulator/output width is 2*N. Legal N >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset; clears accumulator
- x  input  N  unsigned multiplicand (data operand)
- w  input  N  unsigned multiplier (weight operand)
- out  output  2N  accumulator value, registered

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clk and rst.
- State is a single 2N-bit accumulator register, acc. out is driven directly from acc; no combinational path from x/w to out.
- Rising edge of clk with rst=1: acc <= 0. Inputs are ignored that cycle.
- Rising edge of clk with rst=0: acc <= (acc + x*w) mod 2^(2N).
- Latency:
  - Operands sampled at edge k appear in out after edge k.
  - One-cycle latency, one MAC per cycle, no stall or enable.
- Arithmetic:
  - Both operands unsigned.
  - Full 2N-bit product; no truncation of the product.
  - Sum wraps modulo 2^(2N). No saturation, no overflow flag.
- x=0 or w=0: accumulator holds its value.
- Reset asserted mid-accumulation: accumulator cleared on the next edge regardless of operands; accumulation restarts from 0 on the first edge with rst=0.
- Before the first reset edge, out is undefined. The bench must reset before checking.
- Reset value of out: 0.
- Implementation note: multiplier may be a synthesisable combinational array/shift-add structure or the native operator, provided the full 2N-bit product is formed in one cycle.

Test Plan:
- Reset:
  - Stimulus: assert rst for one edge with arbitrary x/w.
  - Response: out = 0 after that edge.
  - Stimulus: hold rst for several edges.
  - Response: out stays 0.
- Accumulation sequence, N=8:
  - Stimulus: after reset, apply (x,w) = (5,2), (3,4), (7,9), (8,6) on successive edges.
  - Response: out = 10, 22, 85, 133.
  - Stimulus: then apply (0,0) for two edges.
  - Response: out stays 133.
- Wrap-around, N=8:
  - Stimulus: after reset, apply (255,255) twice.
  - Response: out = 65025, then 64514 (130050 mod 65536).
- Reset mid-operation:
  - Stimulus: accumulate (5,2), (3,4) to reach 22, then assert rst with x=7, w=9.
  - Response: out = 0.
  - Stimulus: deassert rst, then apply (7,9).
  - Response: out = 63.
- Parameter override, N=4:
  - Stimulus: after reset, apply (15,15) twice.
  - Response: out = 225, then 194 (450 mod 256).
  - Stimulus: apply (2,3).
  - Response: out = 200.
- Registered output check:
  - Stimulus: change x/w between clock edges.
  - Response: out changes only at rising clk edges, never combinationally.

Source files
------------

// File: rtl/mac_if.sv
// Operand/result bundle for the multiply-accumulate unit.
// The master drives x/w and observes out; the mac itself is the slave.
interface mac_if #(
  parameter int N = 8
);
  logic [N-1:0]   x;
  logic [N-1:0]   w;
  logic [2*N-1:0] out;

  modport master (output x, output w, input out);
  modport slave  (input x, input w, output out);
endinterface

// File: rtl/mac.sv
// Unsigned multiply-accumulate: acc <= acc + x*w every clock, wrapping at 2N bits.
// out is taken straight from the accumulator register, so operands never reach it combinationally.
module mac #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  mac_if.slave bus
);
  localparam int W = 2 * N;

  logic [W-1:0] pp   [N];
  logic [W-1:0] psum [N+1];
  logic [W-1:0] x_ext;
  logic [W-1:0] acc_reg;
  logic [W-1:0] acc_next;

  assign x_ext   = {{N{1'b0}}, bus.x};
  assign psum[0] = '0;

  // Shift-add array: one partial product per weight bit, summed in a chain
  // so the full 2N-bit product is available within the cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pp
      assign pp[gi]       = bus.w[gi] ? (x_ext << gi) : '0;
      assign psum[gi + 1] = psum[gi] + pp[gi];
    end
  endgenerate

  always_comb begin
    acc_next = acc_reg + psum[N];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

  assign bus.out = acc_reg;
endmodule

// File: tb/tb_mac.sv
// Bench for mac: N=8 and N=4 instances share one stimulus stream, each checked
// against a plain-arithmetic running-sum model.
module tb_mac;
  logic clk;
  logic rst;
  int   tests;
  int   fails;
  longint m8;
  longint m4;

  mac_if #(.N(8)) bus8 ();
  mac_if #(.N(4)) bus4 ();

  mac #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  mac #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: out=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one edge worth of operands, advance the model, then compare both units.
  task automatic cycle(input logic r, input int unsigned a, input int unsigned b,
                       input string tag);
    longint a8, b8, a4, b4;
    a8 = longint'(a & 32'hff);
    b8 = longint'(b & 32'hff);
    a4 = longint'(a & 32'hf);
    b4 = longint'(b & 32'hf);
    rst    = r;
    bus8.x = a8[7:0];
    bus8.w = b8[7:0];
    bus4.x = a4[3:0];
    bus4.w = b4[3:0];
    if (r) begin
      m8 = 0;
      m4 = 0;
    end else begin
      m8 = (m8 + a8 * b8) % 65536;
      m4 = (m4 + a4 * b4) % 256;
    end
    @(posedge clk);
    #1;
    check({tag, "_n8"}, longint'(bus8.out), m8);
    check({tag, "_n4"}, longint'(bus4.out), m4);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m8    = 0;
    m4    = 0;

    // Reset with arbitrary operands, then held for several edges.
    cycle(1'b1, $urandom, $urandom, "reset");
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, $urandom, "reset_hold");

    // Directed accumulation; also pin the N=8 results to literal values.
    cycle(1'b0, 5, 2, "acc1");
    check("acc1_lit", longint'(bus8.out), 10);
    cycle(1'b0, 3, 4, "acc2");
    check("acc2_lit", longint'(bus8.out), 22);
    cycle(1'b0, 7, 9, "acc3");
    check("acc3_lit", longint'(bus8.out), 85);
    cycle(1'b0, 8, 6, "acc4");
    check("acc4_lit", longint'(bus8.out), 133);
    cycle(1'b0, 0, 0, "zero1");
    cycle(1'b0, 0, 0, "zero2");
    check("zero_hold_lit", longint'(bus8.out), 133);
    cycle(1'b0, 0, 200, "x_zero");
    cycle(1'b0, 200, 0, "w_zero");

    // Wrap-around: full-scale operands on both widths.
    cycle(1'b1, 0, 0, "wrap_rst");
    cycle(1'b0, 255, 255, "wrap1");
    check("wrap1_lit", longint'(bus8.out), 65025);
    cycle(1'b0, 255, 255, "wrap2");
    check("wrap2_lit", longint'(bus8.out), 64514);

    // Reset asserted mid-accumulation ignores its operands.
    cycle(1'b1, 0, 0, "mid_rst0");
    cycle(1'b0, 5, 2, "mid_a");
    cycle(1'b0, 3, 4, "mid_b");
    cycle(1'b1, 7, 9, "mid_rst");
    check("mid_rst_lit", longint'(bus8.out), 0);
    cycle(1'b0, 7, 9, "mid_restart");
    check("mid_restart_lit", longint'(bus8.out), 63);

    // N=4 instance: 15*15 twice wraps at 256, then 2*3 added.
    cycle(1'b1, 0, 0, "n4_rst");
    cycle(1'b0, 15, 15, "n4_a");
    check("n4_a_lit", longint'(bus4.out), 225);
    cycle(1'b0, 15, 15, "n4_b");
    check("n4_b_lit", longint'(bus4.out), 194);
    cycle(1'b0, 2, 3, "n4_c");
    check("n4_c_lit", longint'(bus4.out), 200);

    // Operands wiggled between edges must not disturb out.
    for (int i = 0; i < 8; i++) begin
      bus8.x = 8'($urandom);
      bus8.w = 8'($urandom);
      bus4.x = 4'($urandom);
      bus4.w = 4'($urandom);
      #2;
      check("comb_n8", longint'(bus8.out), m8);
      check("comb_n4", longint'(bus4.out), m4);
      cycle(1'b0, $urandom, $urandom, "comb_step");
    end

    // Random operands with occasional resets.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 15) == 0), $urandom, $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
